// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a byte stream (16-bit big-endian word count,
// then big-endian words) and writes each word out. `IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_loader #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE
    } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t POST_DATA = CHK;
`else
    localparam state_t POST_DATA = DONE;
`endif

    localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_WORDS);

    state_t      state;
    state_t      state_next;
    logic [7:0]  hdr_hi;
    logic [15:0] count_n;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] shift;
    logic        accept;
    logic [15:0] n_hdr;
    logic        hdr_overflow;
    logic        last_word;
    logic        idle_like;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign accept       = rx_valid && rx_ready;
    assign n_hdr        = {hdr_hi, rx_data};
    assign hdr_overflow = {16'd0, n_hdr} > DEPTH_LIMIT;
    assign last_word    = (word_idx == (count_n - 16'd1));
    assign idle_like    = (state == IDLE) || (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) state_next = HDR0;
            end
            HDR0: begin
                if (accept) state_next = HDR1;
            end
            HDR1: begin
                if (accept) begin
                    if (n_hdr == 16'd0)  state_next = POST_DATA;
                    else if (hdr_overflow) state_next = DONE;
                    else                   state_next = DATA;
                end
            end
            DATA: begin
                if (accept && (byte_cnt == 2'd3) && last_word) state_next = POST_DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                if (accept) state_next = DONE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rx_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            HDR0, HDR1, DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
`endif
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Word assembly: the first three bytes wait in shift, the fourth completes the write
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en    <= 1'b0;
            wr_addr  <= 32'd0;
            wr_data  <= 32'd0;
            error    <= 1'b0;
            hdr_hi   <= 8'd0;
            count_n  <= 16'd0;
            word_idx <= 16'd0;
            byte_cnt <= 2'd0;
            shift    <= 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= 8'd0;
`endif
        end else begin
            wr_en <= 1'b0;
            if (idle_like && start) begin
                error    <= 1'b0;
                word_idx <= 16'd0;
                byte_cnt <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum     <= 8'd0;
`endif
            end
            if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum <= csum ^ rx_data;
`endif
                case (state)
                    HDR0: hdr_hi <= rx_data;
                    HDR1: begin
                        count_n <= n_hdr;
                        if (hdr_overflow) error <= 1'b1;
                    end
                    DATA: begin
                        if (byte_cnt == 2'd3) begin
                            wr_en    <= 1'b1;
                            wr_addr  <= {14'd0, word_idx, 2'b00};
                            wr_data  <= {shift, rx_data};
                            word_idx <= word_idx + 16'd1;
                            byte_cnt <= 2'd0;
                        end else begin
                            shift    <= {shift[15:0], rx_data};
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    CHK: begin
                        if (rx_data != csum) error <= 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader: a byte-stream model predicts the
// writes and flags, and a per-cycle monitor compares every write strobe against it.
module tb_imem_loader;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        error;

    int          checks = 0;
    int          errors = 0;
    logic        checking = 1'b0;
    logic [7:0]  stream[$];
    logic [63:0] exp_q[$];
    logic        exp_error;
    int          wr_count = 0;
    logic [31:0] last_addr;
    logic [31:0] last_data;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH_WORDS(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected writes and error flag derived purely from the byte stream contents
    function automatic void build_model();
        int n;
        logic [7:0] x;
        exp_q.delete();
        exp_error = 1'b0;
        n = {stream[0], stream[1]};
        if (n > DEPTH) begin
            exp_error = 1'b1;
        end else begin
            for (int k = 0; k < n; k++)
                exp_q.push_back({32'(4 * k), stream[2+4*k], stream[3+4*k], stream[4+4*k], stream[5+4*k]});
`ifdef IMEM_LOADER_CHECKSUM_EN
            x = 8'd0;
            for (int i = 0; i < stream.size() - 1; i++) x ^= stream[i];
            if (stream[stream.size()-1] != x) exp_error = 1'b1;
`endif
        end
    endfunction

    task automatic add_checksum(input bit corrupt);
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] x = 8'd0;
        foreach (stream[i]) x ^= stream[i];
        stream.push_back(corrupt ? (x ^ 8'h5A) : x);
`else
        if (corrupt) stream.push_back(8'h00);
`endif
    endtask

    task automatic make_load(input int n);
        stream.delete();
        stream.push_back(8'(n >> 8));
        stream.push_back(8'(n));
        if (n <= DEPTH) begin
            for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
            add_checksum(1'b0);
        end
    endtask

    // mode 0: rx_valid held high, 1: toggles each cycle, 2: random; limit < 0 sends the whole stream
    task automatic apply_stimulus(input int mode, input bit inject_start, input int limit);
        int idx = 0;
        int cyc = 0;
        int lim;
        int w0;
        int n_exp;
        int budget;
        logic v;
        logic acc;
        logic tog = 1'b1;
        build_model();
        n_exp  = exp_q.size();
        w0     = wr_count;
        lim    = (limit < 0) ? stream.size() : limit;
        budget = 8 * stream.size() + 50;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("done_cleared", done, 0);
        check("error_cleared", error, 0);
        while (idx < lim && cyc < budget) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
            tog = ~tog;
            rx_valid = v;
            rx_data  = stream[idx];
            start    = inject_start && (cyc == 3);
            acc      = v && rx_ready;
            @(negedge clk);
            cyc++;
            if (acc) idx++;
        end
        rx_valid = 1'b0;
        start    = 1'b0;
        check("bytes_accepted", idx, lim);
        if (limit >= 0) return;
        if (mode == 0) check("no_bubble", cyc, stream.size());
        check("rx_ready_drop", rx_ready, 0);
        #1;
        check("writes_pending", exp_q.size(), 0);
        check("write_count", wr_count - w0, n_exp);
        check("done_flag", done, 1);
        check("error_flag", error, exp_error);
        check("busy_low", busy, 0);
        repeat (2) @(negedge clk);
        check("done_sticky", done, 1);
        check("error_sticky", error, exp_error);
    endtask

    task automatic check_output_reset();
        check("rst_rx_ready", rx_ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
    endtask

    // Per-cycle monitor: every strobe must match the next predicted write
    always @(negedge clk) begin
        if (checking) begin
            check("busy_done_exclusive", 32'(busy & done), 0);
            check("ready_tracks_busy", rx_ready, busy);
            if (wr_en) begin
                wr_count++;
                last_addr = wr_addr;
                last_data = wr_data;
                check("wr_addr_range", 32'(wr_addr <= 32'(4 * (DEPTH - 1))), 1);
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", wr_en, 0);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    check("wr_addr", wr_addr, e[63:32]);
                    check("wr_data", wr_data, e[31:0]);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'd0;
        repeat (3) @(negedge clk);
        check_output_reset();
        rst = 1'b0;
        checking = 1'b1;
        @(negedge clk);

        // single word, literal payload
        stream = '{8'h00, 8'h01, 8'h8C, 8'h01, 8'h00, 8'h04};
        add_checksum(1'b0);
        build_model();
        check("model_single_data", exp_q[0][31:0], 32'h8C010004);
        apply_stimulus(0, 1'b0, -1);
        check("single_addr", last_addr, 32'h0);
        check("single_data", last_data, 32'h8C010004);

        // three words back-to-back, with a start pulse mid-load that must be ignored
        make_load(3);
        build_model();
        check("model_three_words", exp_q.size(), 3);
        apply_stimulus(0, 1'b1, -1);
        check("three_last_addr", last_addr, 32'h8);

        // overflow header 0x0401
        stream = '{8'h04, 8'h01};
        apply_stimulus(0, 1'b0, -1);
        check("overflow_error", error, 1);

        // reset after two data bytes, then a fresh single-word load
        make_load(1);
        apply_stimulus(0, 1'b0, 4);
        exp_q.delete();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output_reset();
        stream = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        add_checksum(1'b0);
        apply_stimulus(0, 1'b0, -1);
        check("fresh_addr", last_addr, 32'h0);
        check("fresh_data", last_data, 32'hDEADBEEF);

        // toggling rx_valid, N=2
        make_load(2);
        apply_stimulus(1, 1'b0, -1);

        // zero-length load
        make_load(0);
        apply_stimulus(0, 1'b0, -1);

        // full capacity: last write lands on the top word
        make_load(DEPTH);
        apply_stimulus(0, 1'b0, -1);
        check("full_last_addr", last_addr, 32'hFFC);

        for (int t = 0; t < 12; t++) begin
            make_load($urandom_range(1, 6));
            apply_stimulus($urandom_range(0, 2), 1'($urandom_range(0, 1)), -1);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
        apply_stimulus(0, 1'b0, -1);
        check("chk_good_error", error, 0);
        stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00};
        apply_stimulus(0, 1'b0, -1);
        check("chk_bad_error", error, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the instruction memory capacity in 32-bit words.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
REQ-005 SHALL have port rx_valid  input  1  byte-stream valid.
REQ-006 SHALL have port rx_data  input  8  byte-stream payload.
REQ-007 SHALL have port rx_ready  output  1  byte accepted when rx_valid and rx_ready are both high on a rising edge.
REQ-008 SHALL have port wr_en  output  1  one-cycle instruction-memory write strobe.
REQ-009 SHALL have port wr_addr  output  32  byte address of the write, word aligned (bits [1:0] = 0).
REQ-010 SHALL have port wr_data  output  32  instruction word to write.
REQ-011 SHALL have port busy  output  1  high from start acceptance until DONE; holds the CPU in stall.
REQ-012 SHALL have port done  output  1  sticky completion flag.
REQ-013 SHALL have port error  output  1  sticky load-failure flag.

Function
REQ-014 SHALL implement states IDLE, HDR0, HDR1, DATA, CHK (only with macro), DONE.
REQ-015 IDLE/DONE: rx_ready=0, busy=0; start -> HDR0, clearing done, error, word counter and byte counter.
REQ-016 HDR0/HDR1: rx_ready=1; accepted bytes form 16-bit word count N, big-endian (HDR0 byte = N[15:8]).
REQ-017 After HDR1: N=0 -> CHK (with macro) or DONE; N > DEPTH_WORDS -> error=1, DONE, no writes; else -> DATA.
REQ-018 DATA: rx_ready=1; bytes assemble big-endian, first byte of each word to wr_data[31:24].
REQ-019 The cycle after the 4th byte of word k is accepted, wr_en SHALL be 1 for exactly one cycle with wr_addr = 4*k, wr_data = assembled word; k counts from 0.
REQ-020 rx_ready SHALL stay high during the write cycle; next word's bytes may be accepted back-to-back with no bubble.
REQ-021 After the 4th byte of word N-1 is accepted, rx_ready SHALL drop the next cycle; state -> CHK or DONE in the same cycle as that word's wr_en.
REQ-022 DONE: done=1 and busy=0 until next start or rst; wr_en=0.
REQ-023 rx_valid low SHALL stall the FSM with no state change; partial words held.
REQ-024 start while busy SHALL be ignored.
REQ-025 wr_addr SHALL never exceed 4*(DEPTH_WORDS-1).

Reset
REQ-026 rst SHALL force IDLE; rx_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, error=0.
REQ-027 rst mid-load SHALL discard the partial word and counters; no wr_en in the cycle after rst; prior writes are not undone.

Configuration
REQ-028 Macro IMEM_LOADER_CHECKSUM_EN defined: running XOR of every accepted byte (header and data); CHK state accepts one byte with rx_ready=1; mismatch sets error=1; then DONE with done=1.
REQ-029 Macro undefined: no CHK state, no checksum logic; error arises only from REQ-017 overflow.

Verification
REQ-030 start, bytes 00 01 8C 01 00 04 -> one wr_en, wr_addr=0x0, wr_data=0x8C010004, done=1, error=0.
REQ-031 N=3, 12 bytes back-to-back, rx_valid held high -> wr_en at addresses 0x0, 0x4, 0x8, 3 consecutive bytes accepted per gap, rx_ready low after 14th byte.
REQ-032 header 04 01 (N=1025, DEPTH_WORDS=1024) -> error=1, done=1, wr_en never asserted.
REQ-033 rst asserted after 2 of 4 data bytes, then fresh load of N=1 word 0xDEADBEEF -> single wr_en at 0x0 with 0xDEADBEEF.
REQ-034 with IMEM_LOADER_CHECKSUM_EN, payload 00 01 12 34 56 78 then checksum 0x09 -> error=0; checksum 0x00 -> error=1.
REQ-035 rx_valid toggled 1/0 each cycle during N=2 load -> same writes as back-to-back, 2 wr_en pulses total.
